regfile_dump_reader: RTL and testbench

- Read-side companion to the 32-entry integer register file. The register file is written by writeback; this block walks its read port and streams every register out.
- Walks raddr 0..2**ADDR_WIDTH-1 and emits {index, value} pairs over a valid/ready stream.
- Consumers are the debug/trace path and the simulation reg-dump logic. They no longer need a full-array DPI export.
- Sits beside the register file and owns one dedicated combinational read port.

---
 rtl/regfile_dump_reader_if.sv | 24 ++
 rtl/regfile_dump_reader.sv | 137 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader: one {index, value} entry
// per valid/ready handshake, with a flag marking the final index.
interface regfile_dump_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // The dump reader produces entries.
    modport master (
        output out_valid, out_addr, out_data, out_last,
        input  out_ready
    );

    // The debug/trace consumer accepts entries.
    modport slave (
        input  out_valid, out_addr, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks the dedicated combinational read port from
// index 0 to the last index and streams every {index, value} pair out over a
// valid/ready interface. A dump can be cancelled at any time with abort.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    regfile_dump_reader_if.master dump,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_d, done_d;
    logic                  handshake;

    assign handshake = valid_q && dump.out_ready;

    // Next-state and next-output decode for the dump walk.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                // A simultaneous abort suppresses the start request.
                if (start && !abort) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                // Capture the read port now; a same-cycle writeback to this
                // index lands after the edge, so the old value is emitted.
                data_d  = rf_rdata;
                addr_d  = idx_q;
                last_d  = (idx_q == LAST_IDX);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Abort outranks everything, including a handshake in the same
        // cycle: that entry is treated as not delivered.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; reset clears the dump immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Read address is decoded straight from state/idx so the file returns
    // data for the current index within the READ cycle.
    always_comb begin
        rf_raddr = (state_q == IDLE) ? '0 : idx_q;
    end

    assign dump.out_valid = valid_q;
    assign dump.out_addr  = addr_q;
    assign dump.out_data  = data_q;
    assign dump.out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a small register-file model feeds the read
// port, a table of dump scenarios drives start/ready/abort/writeback, and a
// scoreboard queue holds the entries each dump should deliver.
module tb_regfile_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          busy;
    logic          done;

    regfile_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dif ();

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .dump     (dif),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read.
    logic [DW-1:0] rf [N];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end
    assign rf_rdata = rf[rf_raddr];

    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t sb[$];

    typedef struct {
        int stall_idx;    // entry held with out_ready=0, -1 for none
        int stall_len;    // cycles of backpressure on that entry
        int abort_idx;    // entry aborted while in SEND, -1 for none
        int collide_idx;  // index written during its READ cycle, -1 for none
        int exp_entries;  // entries expected to be delivered
        int exp_done;     // expected number of done pulses
        int exp_done_cyc; // cycle of done, counted from the start edge
    } run_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One dump scenario. Called at a negedge with the DUT idle; cycle n is the
    // interval ending at the n-th edge after the start edge.
    task automatic run_dump(input run_t r);
        int     cyc       = 0;
        int     delivered = 0;
        int     done_cnt  = 0;
        int     done_cyc  = 0;
        int     stall_cnt = 0;
        int     last_hs   = 0;
        int     abort_cyc = 0;
        int     end_cyc   = 0;
        logic   rdy, st, ab;
        logic   prev_valid = 1'b0;
        logic   collided   = 1'b0;
        entry_t e;

        for (int i = 0; i < N; i++) begin
            sb.push_back(entry_t'{last: (i == N - 1), addr: AW'(i), data: rf[i]});
        end

        start = 1'b1;
        abort = 1'b0;
        dif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (end_cyc == 0 || cyc < end_cyc) begin
            cyc++;
            if (cyc > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL dump_timeout: no completion after %0d cycles", cyc);
                break;
            end
            rdy   = 1'b1;
            st    = 1'b0;
            ab    = 1'b0;
            wr_en = 1'b0;

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt == 0 && abort_cyc == 0) check("busy_during_dump", busy, 1);
            if (done_cnt > 0 && cyc == done_cyc + 1) check("idle_after_done", busy, 0);
            if (dif.out_valid && !prev_valid) check("entry_latency", cyc, last_hs + 2);

            if (dif.out_valid && int'(dif.out_addr) == r.stall_idx && stall_cnt < r.stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
                if (sb.size() > 0) check("stall_hold", {dif.out_last, dif.out_addr, dif.out_data}, sb[0]);
            end
            if (dif.out_valid && int'(dif.out_addr) == r.abort_idx && abort_cyc == 0) begin
                ab = 1'b1;
                abort_cyc = cyc;
            end
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                check("abort_valid", dif.out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_last", dif.out_last, 0);
            end
            if (r.collide_idx >= 0 && !collided && busy && !dif.out_valid &&
                int'(rf_raddr) == r.collide_idx) begin
                wr_en   = 1'b1;
                wr_addr = AW'(r.collide_idx);
                wr_data = 32'hDEAD_BEEF;
                collided = 1'b1;
            end
            // Start pulses while busy must be ignored.
            if (done_cnt == 0 && abort_cyc == 0 && !ab && (cyc % 5) == 3) st = 1'b1;

            if (dif.out_valid && rdy && !ab) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: addr %0d with empty scoreboard", dif.out_addr);
                end else begin
                    e = sb.pop_front();
                    check("entry", {dif.out_last, dif.out_addr, dif.out_data}, e);
                end
                delivered++;
                last_hs = cyc;
            end

            start = st;
            abort = ab;
            dif.out_ready = rdy;
            prev_valid = dif.out_valid;
            if (end_cyc == 0 && (done_cnt > 0 || abort_cyc > 0)) end_cyc = cyc + 3;
            @(negedge clk);
        end

        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        check("entries_delivered", delivered, r.exp_entries);
        check("done_count", done_cnt, r.exp_done);
        if (r.exp_done > 0) check("done_cycle", done_cyc, r.exp_done_cyc);
        sb.delete();
    endtask

    initial begin
        run_t runs[7];
        int   wait_cnt;
        int   done_seen;

        runs[0] = '{-1, 0, -1, -1, 32, 1, 65};  // plain dump, ready held high
        runs[1] = '{ 3, 5, -1, -1, 32, 1, 70};  // backpressure on entry 3
        runs[2] = '{-1, 0, 10, -1, 10, 0,  0};  // abort at entry 10 with ready
        runs[3] = '{-1, 0, -1,  5, 32, 1, 65};  // writeback collides with READ of 5
        runs[4] = '{-1, 0, -1, -1, 32, 1, 65};  // repeat: rf[5] now 0xDEADBEEF
        runs[5] = '{31, 3, -1, -1, 32, 1, 68};  // backpressure on the last entry
        runs[6] = '{-1, 0,  0, -1,  0, 0,  0};  // abort on the very first entry

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        dif.out_ready = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        @(negedge clk);
        @(negedge clk);

        check("reset_valid", dif.out_valid, 0);
        check("reset_addr", dif.out_addr, 0);
        check("reset_data", dif.out_data, 0);
        check("reset_last", dif.out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_raddr", rf_raddr, 0);

        // Preload the file through its write port while the dumper is held.
        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // start together with abort in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        @(negedge clk);
        check("start_abort_idle_valid", dif.out_valid, 0);

        for (int k = 0; k < 7; k++) begin
            run_dump(runs[k]);
            @(negedge clk);
        end

        // Asynchronous reset while holding entry 20 in SEND.
        start = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (!(dif.out_valid && dif.out_addr == AW'(20)) && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach_entry_20", dif.out_addr, 20);
        dif.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", dif.out_valid, 0);
        check("async_rst_addr", dif.out_addr, 0);
        check("async_rst_data", dif.out_data, 0);
        check("async_rst_last", dif.out_last, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_raddr", rf_raddr, 0);
        @(negedge clk);
        rst = 1'b0;
        dif.out_ready = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || dif.out_valid) done_seen++;
        end
        check("quiet_after_reset", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
